// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding,
// counter bit-index constants, parity-type encodings and small helpers.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Bit_number values presented by the bit counter
  localparam logic [3:0] BITN_START      = 4'd0;
  localparam logic [3:0] BITN_FIRST_DATA = 4'd1;

  // PAR_TYP encodings
  localparam logic PAR_TYP_EVEN = 1'b0;
  localparam logic PAR_TYP_ODD  = 1'b1;

  // Two-out-of-three vote used to reject single-sample noise
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-deep sample history of the serial line plus the majority vote that
// produces the bit value at the bit-centre strobe (uses the live line value
// as the third vote).
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  input  logic take_sample,
  output logic samp_bit
);

  logic [1:0] samp_q;
  logic [1:0] samp_d;

  // Shift the line value into the history on every sample strobe
  always_comb begin
    samp_d = samp_q;
    if (take_sample) begin
      samp_d = {samp_q[0], rx_in};
    end else begin
      samp_d = samp_q;
    end
  end

  // Sample history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= 2'b00;
    end else begin
      samp_q <= samp_d;
    end
  end

  assign samp_bit = majority3(samp_q[1], samp_q[0], rx_in);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller. Detects the start edge, drives the bit
// counter, deserialises LSB-first data, checks parity and stop bit and emits
// one byte per good frame.
// Optional build macro UART_RX_ERR_CNT_EN adds saturating 8-bit parity and
// stop error counters (Par_Err_Cnt, Stp_Err_Cnt).
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Take_Sample,
  input  logic                  Valid,
  input  logic [3:0]            Bit_number,
  output logic                  Counter_En,
  output logic                  New_Fram,
  output logic                  Serial_En,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            Par_Err_Cnt,
  output logic [7:0]            Stp_Err_Cnt
`endif
);

  localparam logic [3:0] LAST_DATA_BITN = BITN_FIRST_DATA + 4'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_bad_q, par_bad_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  serial_en_q, serial_en_d;

  logic                  samp_bit_s;
  logic                  start_det_s;
  logic                  exp_par_s;

  uart_rx_sampler u_sampler (
    .clk         (CLK),
    .rst_n       (RSTn),
    .rx_in       (RX_IN),
    .take_sample (Take_Sample),
    .samp_bit    (samp_bit_s)
  );

  // Start edge only counts out of reset so the counter interface is quiet
  // while RSTn is held, whatever the line is doing.
  assign start_det_s = RSTn & (state_q == IDLE) & ~RX_IN;
  assign exp_par_s   = par_acc_q ^ (par_typ_q != PAR_TYP_EVEN);

  assign New_Fram   = start_det_s;
  assign Counter_En = ((state_q != IDLE) && (state_q != BREAK)) || start_det_s;
  assign Serial_En  = serial_en_q;
  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign Par_Err    = par_err_q;
  assign Stp_Err    = stp_err_q;

  // Next-state, datapath and registered-output computation for the frame FSM
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    par_acc_d    = par_acc_q;
    par_bad_d    = par_bad_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    // Frame configuration is frozen at the start edge
    if (start_det_s) begin
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      par_acc_d = 1'b0;
      par_bad_d = 1'b0;
    end else begin
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
    end

    case (state_q)
      IDLE: begin
        if (start_det_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (Valid) begin
          // A high start-bit centre means the edge was a glitch
          state_d = samp_bit_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        if (Valid) begin
          shift_d   = {samp_bit_s, shift_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ samp_bit_s;
          if (Bit_number == LAST_DATA_BITN) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end

      PARITY: begin
        if (Valid) begin
          par_bad_d = (samp_bit_s != exp_par_s);
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end

      STOP: begin
        if (Valid) begin
          if (samp_bit_s) begin
            // Back to IDLE at the stop centre so a tight next start is caught
            state_d = IDLE;
            if (par_bad_q) begin
              par_err_d = 1'b1;
            end else begin
              data_valid_d = 1'b1;
              p_data_d     = shift_q;
            end
          end else begin
            stp_err_d = 1'b1;
            par_err_d = par_bad_q;
            state_d   = BREAK;
          end
        end else begin
          state_d = STOP;
        end
      end

      BREAK: begin
        // A held-low line must go high again before a new frame can start
        if (RX_IN) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    serial_en_d = (state_d == DATA);
  end

  // Frame FSM state, datapath and registered output pulses
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      serial_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      par_acc_q    <= par_acc_d;
      par_bad_q    <= par_bad_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      serial_en_q  <= serial_en_d;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] par_err_cnt_q, par_err_cnt_d;
  logic [7:0] stp_err_cnt_q, stp_err_cnt_d;

  // Counters step in the same cycle their error pulse becomes visible
  always_comb begin
    par_err_cnt_d = par_err_cnt_q;
    stp_err_cnt_d = stp_err_cnt_q;
    if (par_err_d) begin
      par_err_cnt_d = sat_inc8(par_err_cnt_q);
    end else begin
      par_err_cnt_d = par_err_cnt_q;
    end
    if (stp_err_d) begin
      stp_err_cnt_d = sat_inc8(stp_err_cnt_q);
    end else begin
      stp_err_cnt_d = stp_err_cnt_q;
    end
  end

  // Saturating error counter registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      par_err_cnt_q <= 8'd0;
      stp_err_cnt_q <= 8'd0;
    end else begin
      par_err_cnt_q <= par_err_cnt_d;
      stp_err_cnt_q <= stp_err_cnt_d;
    end
  end

  assign Par_Err_Cnt = par_err_cnt_q;
  assign Stp_Err_Cnt = stp_err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a behavioural bit counter feeds the DUT, frames are
// built from data/parity/stop rules, expected results go into a scoreboard
// queue and a monitor compares every output pulse against it.
module tb_uart_rx_fsm;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_in;
  logic          par_en;
  logic          par_typ;
  logic          take_sample;
  logic          valid;
  logic [3:0]    bit_number;
  logic          counter_en;
  logic          new_fram;
  logic          serial_en;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]    par_err_cnt;
  logic [7:0]    stp_err_cnt;
`endif

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK         (clk),
    .RSTn        (rst_n),
    .RX_IN       (rx_in),
    .PAR_EN      (par_en),
    .PAR_TYP     (par_typ),
    .Take_Sample (take_sample),
    .Valid       (valid),
    .Bit_number  (bit_number),
    .Counter_En  (counter_en),
    .New_Fram    (new_fram),
    .Serial_En   (serial_en),
    .P_DATA      (p_data),
    .Data_Valid  (data_valid),
    .Par_Err     (par_err),
    .Stp_Err     (stp_err)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .Par_Err_Cnt (par_err_cnt),
    .Stp_Err_Cnt (stp_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural bit counter ----------------
  int         prescale = 8;
  logic       run_q;
  int         ecnt;
  logic [3:0] bitn_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      ecnt   <= 0;
      bitn_q <= 4'd0;
    end else if (new_fram) begin
      run_q  <= 1'b1;
      ecnt   <= 1;
      bitn_q <= 4'd0;
    end else if (run_q && counter_en) begin
      if (ecnt == prescale - 1) begin
        ecnt   <= 0;
        bitn_q <= bitn_q + 4'd1;
      end else begin
        ecnt <= ecnt + 1;
      end
    end else begin
      run_q  <= 1'b0;
      ecnt   <= 0;
      bitn_q <= 4'd0;
    end
  end

  assign take_sample = run_q && (ecnt >= prescale/2 - 2) && (ecnt <= prescale/2);
  assign valid       = run_q && (ecnt == prescale/2);
  assign bit_number  = bitn_q;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] pdata;
  } exp_t;

  exp_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            nf_seen = 0;
  int            nf_exp = 0;
  logic [DW-1:0] last_good = '0;
  int            exp_pe_cnt = 0;
  int            exp_se_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pop an expectation on every output pulse
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && new_fram) nf_seen++;
    if (data_valid || par_err || stp_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_flags", {29'd0, data_valid, par_err, stp_err},
              {29'd0, e.dv, e.pe, e.se});
        check("p_data", {24'd0, p_data}, {24'd0, e.pdata});
      end
    end
  end

  // Build and drive one frame; the expected outcome comes from the frame rules
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic bad_par, input logic stop_bit, input logic glitch);
    logic bits [0:11];
    int   nbits;
    int   gbit;
    int   gj;
    logic pbit;
    exp_t e;

    @(negedge clk);
    par_en  = pe;
    par_typ = pt;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    nbits = 1 + DW;
    // even parity: total ones including parity bit is even; odd: odd
    pbit = 1'(($countones(d) % 2) != 0) ^ pt;
    if (pe) begin
      bits[nbits] = pbit ^ bad_par;
      nbits++;
    end
    bits[nbits] = stop_bit;
    nbits++;

    if (!stop_bit) begin
      e = '{dv: 1'b0, pe: (pe && bad_par), se: 1'b1, pdata: last_good};
      exp_se_cnt++;
      if (pe && bad_par) exp_pe_cnt++;
    end else if (pe && bad_par) begin
      e = '{dv: 1'b0, pe: 1'b1, se: 1'b0, pdata: last_good};
      exp_pe_cnt++;
    end else begin
      e = '{dv: 1'b1, pe: 1'b0, se: 1'b0, pdata: d};
      last_good = d;
    end
    exp_q.push_back(e);
    nf_exp++;

    gbit = 1 + int'($urandom_range(0, DW - 1));
    gj   = prescale/2 - 2 + int'($urandom_range(0, 2));

    rx_in = bits[0];
    for (int n = 0; n < nbits; n++) begin
      for (int j = 0; j < prescale; j++) begin
        if (!(n == 0 && j == 0)) @(negedge clk);
        rx_in = bits[n] ^ (glitch && n == gbit && j == gj);
        #1;
        if (n >= 1 && n <= DW && j == 0) check("serial_en_data", {31'd0, serial_en}, 32'd1);
        if (n == nbits - 1 && j == 0) check("serial_en_stop", {31'd0, serial_en}, 32'd0);
        if (n == nbits - 1 && j == prescale - 1 && stop_bit)
          check("idle_after_stop", {31'd0, counter_en}, 32'd0);
      end
    end

    if (!stop_bit) begin
      repeat (40) begin
        @(negedge clk);
        rx_in = 1'b0;
        #1;
        check("break_cnt_en", {30'd0, counter_en, new_fram}, 32'd0);
      end
      @(negedge clk);
      rx_in = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  // Short low pulse on an idle line: must be rejected at the start centre
  task automatic glitch_start();
    @(negedge clk);
    rx_in = 1'b0;
    nf_exp++;
    @(negedge clk);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (prescale + 4) @(negedge clk);
    #1;
    check("glitch_idle", {31'd0, counter_en}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt_en"}, {31'd0, counter_en}, 32'd0);
    check({tag, "_new_fram"}, {31'd0, new_fram}, 32'd0);
    check({tag, "_serial_en"}, {31'd0, serial_en}, 32'd0);
    check({tag, "_p_data"}, {24'd0, p_data}, 32'd0);
    check({tag, "_pulses"}, {29'd0, data_valid, par_err, stp_err}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    check({tag, "_err_cnts"}, {16'd0, par_err_cnt, stp_err_cnt}, 32'd0);
`endif
  endtask

  initial begin
    logic [DW-1:0] abort_d;
    rst_n   = 1'b0;
    rx_in   = 1'b1;
    par_en  = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame, no parity
    prescale = 8;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Even parity, correct then corrupted parity bit
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Start glitch at a longer bit period
    prescale = 16;
    glitch_start();
    // Framing error, held-low break, then recovery
    prescale = 8;
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Back-to-back frames, second with a single-sample glitch
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of the data of 0x81 while the line is low
    repeat (3) @(negedge clk);
    abort_d = 8'h81;
    nf_exp++;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (prescale - 1) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < prescale; j++) begin
        @(negedge clk);
        rx_in = abort_d[n];
      end
    end
    for (int j = 0; j < prescale/2; j++) begin
      @(negedge clk);
      rx_in = abort_d[3];
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    last_good  = '0;
    exp_pe_cnt = 0;
    exp_se_cnt = 0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
    repeat (2) @(negedge clk);
    #1;
    check("cnts_after_rst", {16'd0, par_err_cnt, stp_err_cnt}, 32'd0);
`endif

    // Randomised frames
    for (int k = 0; k < 30; k++) begin
      prescale = ($urandom_range(0, 1) != 0) ? 16 : 8;
      send_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 2) == 0));
    end

    repeat (20) @(negedge clk);
    #2;
    check("pending_expectations", exp_q.size(), 32'd0);
    check("new_fram_count", nf_seen, nf_exp);
`ifdef UART_RX_ERR_CNT_EN
    check("par_err_cnt", {24'd0, par_err_cnt}, exp_pe_cnt);
    check("stp_err_cnt", {24'd0, stp_err_cnt}, exp_se_cnt);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
